alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
- Shares one combinational alu_sum instance between NUM_REQ issue lanes of the superscalar core.
- Selects requesters round-robin and registers the winner's operands and opcode into the ALU inputs.
- Captures the ALU result into a response register that supports backpressure.
- Sits between the issue stage lanes and the shared ALU; the writeback/bypass logic consumes the response.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the attached alu_sum.
- NUM_REQ, 2, number of requesting lanes; legal range 2..4.
- TAG_WIDTH, 4, destination tag carried with each operation.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-lane request valid.
- req_ready  output  NUM_REQ  per-lane accept; at most one bit high per cycle.
- req_a  input  NUM_REQ*DATA_WIDTH  operand a; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  input  NUM_REQ*DATA_WIDTH  operand b; same packing as req_a.
- req_op  input  NUM_REQ*4  alucontrol code per lane.
- req_tag  input  NUM_REQ*TAG_WIDTH  tag per lane.
- alu_a  output  DATA_WIDTH  registered operand a to ALU.
- alu_b  output  DATA_WIDTH  registered operand b to ALU.
- alu_control  output  4  registered opcode to ALU.
- alu_out  input  DATA_WIDTH  combinational ALU result.
- resp_valid  output  1  response valid.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  DATA_WIDTH  result.
- resp_tag  output  TAG_WIDTH  tag of the result.
- resp_src  output  2  index of the originating lane.
- resp_err  output  1  opcode was illegal.

Behaviour:
- Reset:
  - Clears alu_a, alu_b, alu_control, resp_data, resp_tag, resp_src and resp_err to 0.
  - Deasserts resp_valid and both pipeline-stage valids.
  - Sets the round-robin pointer to 0.
  - Any in-flight operation is dropped, never replayed; asserting reset mid-operation has exactly the same effect.
- Legal opcodes are 0 (AND), 1 (OR), 2 (ADD) and 6 (SUB).
  - Any other code passes through S1 with an err flag set.
  - S2 then loads resp_data=0 and resp_err=1, ignoring alu_out.
- Pipeline:
  - S1 is the issue register (alu_a, alu_b, alu_control, tag, src, err, s1_valid).
  - S2 is the response register (resp_*).
  - Handshake on req_valid[i] & req_ready[i] at edge N: S1 loads at N, ALU evaluates during N+1, S2 loads at the N+1 edge, resp_valid is high in cycle N+2.
  - Minimum latency is 2 cycles; throughput is 1 operation per cycle when resp_ready stays high.
- Stall rules:
  - s2_free = !resp_valid | resp_ready.
  - S1 advances into S2 when s1_valid & s2_free.
  - s1_accept = !s1_valid | s2_free.
  - S2 holds its contents while resp_valid & !resp_ready.
  - A response that is accepted with no S1 entry behind it clears resp_valid.
  - Simultaneous drain of S2, advance of S1 and a new grant into S1 in the same cycle is legal.
- Arbitration:
  - The grant goes to the first asserted req_valid, scanning from the pointer upward modulo NUM_REQ.
  - req_ready[i] = grant[i] & s1_accept; ready depends on valid combinationally.
  - Requesters must not make req_valid depend on req_ready.
  - Once asserted, req_valid and the payload must be held until accepted.
  - After an accepted grant, pointer = granted index + 1, wrapping from NUM_REQ-1 to 0.
  - With no handshake the pointer is unchanged.
  - When no lane is valid, all req_ready bits are 0 and S1 loads nothing.
- Widths: resp_src is 2 bits regardless of NUM_REQ; its upper bit is 0 when NUM_REQ=2.

Optional Feature:
- Macro: ALU_ISSUE_ARBITER_PERF_EN.
- When defined, three 32-bit output ports are added:
  - perf_issued: count of accepted requests.
  - perf_stall: cycles where any req_valid is high and no handshake occurs.
  - perf_illegal: count of illegal opcodes.
- All three counters reset to 0 and wrap modulo 2^32.
- When undefined, the ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Single lane 0, a=5, b=3, op=2, tag=7, resp_ready=1 -> resp_valid exactly 2 cycles after the handshake; data=8, tag=7, src=0, err=0.
- Both lanes valid continuously, op=6 with lane0 a=10/b=4 and lane1 a=1/b=2 -> grants alternate 0,1,0,1; responses alternate 6 and 0xFFFFFFFF at 1 per cycle.
- resp_ready=0 for 4 cycles with lane 0 streaming -> S2 holds the first result, S1 holds the second, req_ready=0 thereafter; after release the results drain in order with no loss or duplication.
- op=3 on lane 1 -> resp_err=1, resp_data=0, src=1; the next legal op is unaffected.
- rst pulsed asynchronously with S1 and S2 full -> all outputs 0 immediately; the next grant goes to lane 0 even if lane 1 is also valid.
- With ALU_ISSUE_ARBITER_PERF_EN defined, run the stall and illegal-op scenarios -> perf_issued, perf_stall and perf_illegal match the handshake, stall-cycle and illegal-op counts computed by the bench.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: round-robin issue of NUM_REQ lanes onto one shared ALU.
// Optional perf counters are built when ALU_ISSUE_ARBITER_PERF_EN is defined.
module alu_issue_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*4-1:0]            req_op,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]    req_tag,
  output logic [DATA_WIDTH-1:0]           alu_a,
  output logic [DATA_WIDTH-1:0]           alu_b,
  output logic [3:0]                      alu_control,
  input  logic [DATA_WIDTH-1:0]           alu_out,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic [TAG_WIDTH-1:0]            resp_tag,
  output logic [1:0]                      resp_src,
  output logic                            resp_err
`ifdef ALU_ISSUE_ARBITER_PERF_EN
  ,
  output logic [31:0]                     perf_issued,
  output logic [31:0]                     perf_stall,
  output logic [31:0]                     perf_illegal
`endif
);

  logic [1:0]            ptr;
  logic [1:0]            gidx;
  logic [NUM_REQ-1:0]    grant;
  logic                  found;
  int                    idx;
  logic                  s1_valid;
  logic                  s1_err;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic [1:0]            s1_src;
  logic                  s2_free;
  logic                  s1_accept;
  logic                  hs;
  logic [DATA_WIDTH-1:0] g_a;
  logic [DATA_WIDTH-1:0] g_b;
  logic [3:0]            g_op;
  logic [TAG_WIDTH-1:0]  g_tag;
  logic                  g_err;

  // Round-robin pick: first valid lane at or above the pointer, wrapping.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        gidx       = 2'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  // Pipeline flow control and winner payload mux.
  always_comb begin
    s2_free   = !resp_valid || resp_ready;
    s1_accept = !s1_valid || s2_free;
    req_ready = grant & {NUM_REQ{s1_accept && !rst}};
    hs        = found && s1_accept && !rst;
    g_a   = req_a[gidx*DATA_WIDTH +: DATA_WIDTH];
    g_b   = req_b[gidx*DATA_WIDTH +: DATA_WIDTH];
    g_op  = req_op[gidx*4 +: 4];
    g_tag = req_tag[gidx*TAG_WIDTH +: TAG_WIDTH];
    g_err = !(g_op inside {4'd0, 4'd1, 4'd2, 4'd6});
  end

  // Pointer moves past the granted lane only on a handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (int'(gidx) == NUM_REQ - 1) ? 2'd0 : gidx + 2'd1;
    end
  end

  // S1 issue register feeding the shared ALU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      s1_tag      <= '0;
      s1_src      <= '0;
      s1_err      <= 1'b0;
    end else if (s1_accept) begin
      s1_valid <= hs;
      if (hs) begin
        alu_a       <= g_a;
        alu_b       <= g_b;
        alu_control <= g_op;
        s1_tag      <= g_tag;
        s1_src      <= gidx;
        s1_err      <= g_err;
      end
    end
  end

  // S2 response register; holds while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
      resp_src   <= '0;
      resp_err   <= 1'b0;
    end else if (s2_free) begin
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_data <= s1_err ? '0 : alu_out;
        resp_tag  <= s1_tag;
        resp_src  <= s1_src;
        resp_err  <= s1_err;
      end
    end
  end

`ifdef ALU_ISSUE_ARBITER_PERF_EN
  // Issue, stall and illegal-opcode event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_issued  <= '0;
      perf_stall   <= '0;
      perf_illegal <= '0;
    end else begin
      if (hs)
        perf_issued <= perf_issued + 32'd1;
      if (|req_valid && !hs)
        perf_stall <= perf_stall + 32'd1;
      if (hs && g_err)
        perf_illegal <= perf_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: scoreboard bench for alu_issue_arbiter.
// Lane queues drive requests; accepted ops push expected responses.
module tb_alu_issue_arbiter;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int TW = 4;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [3:0]  tag;
  } op_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic [1:0]  src;
    logic        err;
    int          cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a = '0;
  logic [NR*DW-1:0]  req_b = '0;
  logic [NR*4-1:0]   req_op = '0;
  logic [NR*TW-1:0]  req_tag = '0;
  logic [DW-1:0]     alu_a;
  logic [DW-1:0]     alu_b;
  logic [3:0]        alu_control;
  logic [DW-1:0]     alu_out;
  logic              resp_valid;
  logic              resp_ready;
  logic [DW-1:0]     resp_data;
  logic [TW-1:0]     resp_tag;
  logic [1:0]        resp_src;
  logic              resp_err;
`ifdef ALU_ISSUE_ARBITER_PERF_EN
  logic [31:0]       perf_issued;
  logic [31:0]       perf_stall;
  logic [31:0]       perf_illegal;
`endif

  op_t  lq0[$];
  op_t  lq1[$];
  exp_t sb[$];
  int   gq[$];
  int   rq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   fl_req = 0;
  int   fl_done = 0;
  int   m_issued = 0;
  int   m_stall = 0;
  int   m_illegal = 0;
  bit   lat_chk = 1'b0;
  bit   any_hs;
  exp_t e;

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b,
                                        logic [3:0] op);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      default: return 32'hdeadbeef;
    endcase
  endfunction

  function automatic bit legal(logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd6};
  endfunction

  function automatic exp_t mk(op_t o, int src, int c);
    exp_t x;
    x.err  = !legal(o.op);
    x.data = x.err ? 32'd0 : alu_f(o.a, o.b, o.op);
    x.tag  = o.tag;
    x.src  = 2'(src);
    x.cyc  = c;
    return x;
  endfunction

  function automatic op_t mkop(logic [31:0] a, logic [31:0] b,
                               logic [3:0] op, logic [3:0] tag);
    op_t o;
    o.a = a;
    o.b = b;
    o.op = op;
    o.tag = tag;
    return o;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shared ALU stand-in.
  assign alu_out = alu_f(alu_a, alu_b, alu_control);

  alu_issue_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .TAG_WIDTH(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .req_op(req_op),
    .req_tag(req_tag),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_control(alu_control),
    .alu_out(alu_out),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_tag(resp_tag),
    .resp_src(resp_src),
    .resp_err(resp_err)
`ifdef ALU_ISSUE_ARBITER_PERF_EN
    ,
    .perf_issued(perf_issued),
    .perf_stall(perf_stall),
    .perf_illegal(perf_illegal)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Lane driver: present each queue head, held until accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      req_valid = {lq1.size() != 0, lq0.size() != 0};
      if (lq0.size() != 0) begin
        req_a[31:0]  = lq0[0].a;
        req_b[31:0]  = lq0[0].b;
        req_op[3:0]  = lq0[0].op;
        req_tag[3:0] = lq0[0].tag;
      end
      if (lq1.size() != 0) begin
        req_a[63:32] = lq1[0].a;
        req_b[63:32] = lq1[0].b;
        req_op[7:4]  = lq1[0].op;
        req_tag[7:4] = lq1[0].tag;
      end
    end
  end

  // Monitor: score handshakes and responses mid-cycle.
  always @(negedge clk) begin
    if (fl_done != fl_req) begin
      sb.delete();
      m_issued = 0;
      m_stall = 0;
      m_illegal = 0;
      fl_done = fl_req;
    end
    if (!rst) begin
      check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      if (resp_valid && resp_ready) begin
        rq.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_resp", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("resp_data", 64'(resp_data), 64'(e.data));
          check("resp_tag", 64'(resp_tag), 64'(e.tag));
          check("resp_src", 64'(resp_src), 64'(e.src));
          check("resp_err", 64'(resp_err), 64'(e.err));
          if (lat_chk)
            check("latency", 64'(cyc - e.cyc), 64'd2);
        end
      end
      any_hs = 1'b0;
      if (req_valid[0] && req_ready[0]) begin
        any_hs = 1'b1;
        sb.push_back(mk(lq0[0], 0, cyc));
        if (!legal(lq0[0].op)) m_illegal++;
        void'(lq0.pop_front());
        gq.push_back(0);
      end
      if (req_valid[1] && req_ready[1]) begin
        any_hs = 1'b1;
        sb.push_back(mk(lq1[0], 1, cyc));
        if (!legal(lq1[0].op)) m_illegal++;
        void'(lq1.pop_front());
        gq.push_back(1);
      end
      if (any_hs) m_issued++;
      if (|req_valid && !any_hs) m_stall++;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    fl_req++;
    #2;
    rst = 1'b0;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while ((lq0.size() != 0 || lq1.size() != 0 || sb.size() != 0 ||
            resp_valid) && n < 300) begin
      @(posedge clk);
      #3;
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n < 300), 64'd1);
  endtask

  task automatic perf_check(string tag);
`ifdef ALU_ISSUE_ARBITER_PERF_EN
    check({tag, "_perf_issued"}, 64'(perf_issued), 64'(m_issued));
    check({tag, "_perf_stall"}, 64'(perf_stall), 64'(m_stall));
    check({tag, "_perf_illegal"}, 64'(perf_illegal), 64'(m_illegal));
`else
    check({tag, "_issued_nonzero"}, 64'(m_issued != 0), 64'd1);
`endif
  endtask

  initial begin
    int g0;
    int r0;
    rst = 1'b0;
    resp_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    check("rst_alu_b", 64'(alu_b), 64'd0);
    check("rst_alu_control", 64'(alu_control), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_resp_src", 64'(resp_src), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;

    // single op latency
    lat_chk = 1'b1;
    lq0.push_back(mkop(32'd5, 32'd3, 4'd2, 4'd7));
    drain("t1");
    lat_chk = 1'b0;

    // two lanes alternate at full rate
    do_reset();
    g0 = gq.size();
    r0 = rq.size();
    for (int i = 0; i < 4; i++) begin
      lq0.push_back(mkop(32'd10, 32'd4, 4'd6, 4'(i)));
      lq1.push_back(mkop(32'd1, 32'd2, 4'd6, 4'(8 + i)));
    end
    drain("t2");
    check("t2_grants", 64'(gq.size() - g0), 64'd8);
    check("t2_resps", 64'(rq.size() - r0), 64'd8);
    if (gq.size() - g0 == 8 && rq.size() - r0 == 8) begin
      for (int k = 0; k < 8; k++)
        check("t2_grant_order", 64'(gq[g0 + k]), 64'(k % 2));
      check("t2_rate", 64'(rq[r0 + 7] - rq[r0]), 64'd7);
    end

    // consumer backpressure
    do_reset();
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      lq0.push_back(mkop(32'(i), 32'd100, 4'd2, 4'(i)));
    repeat (4) @(posedge clk);
    #3;
    check("t3_ready_stalled", 64'(req_ready), 64'd0);
    check("t3_resp_held", 64'(resp_valid), 64'd1);
    check("t3_first_held", 64'(resp_data), 64'd100);
    check("t3_inflight", 64'(sb.size()), 64'd2);
    resp_ready = 1'b1;
    drain("t3");

    // illegal opcode then legal one on lane 1
    lq1.push_back(mkop(32'd9, 32'd9, 4'd3, 4'd5));
    lq1.push_back(mkop(32'd9, 32'd1, 4'd6, 4'd6));
    drain("t4");
    perf_check("t34");

    // async reset with both stages full
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lq0.push_back(mkop(32'd7, 32'd1, 4'd1, 4'd1));
      lq1.push_back(mkop(32'd7, 32'd3, 4'd0, 4'd2));
    end
    repeat (4) @(posedge clk);
    #2;
    check("t5_pre_full", 64'(resp_valid), 64'd1);
    rst = 1'b1;
    fl_req++;
    #1;
    check("t5_resp_valid", 64'(resp_valid), 64'd0);
    check("t5_alu_a", 64'(alu_a), 64'd0);
    check("t5_alu_b", 64'(alu_b), 64'd0);
    check("t5_alu_control", 64'(alu_control), 64'd0);
    check("t5_resp_data", 64'(resp_data), 64'd0);
    check("t5_resp_tag", 64'(resp_tag), 64'd0);
    check("t5_req_ready", 64'(req_ready), 64'd0);
    g0 = gq.size();
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    drain("t5");
    check("t5_grant_count", 64'(gq.size() > g0), 64'd1);
    if (gq.size() > g0)
      check("t5_first_grant", 64'(gq[g0]), 64'd0);
    perf_check("t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
